// File: rtl/sram22_arb_pkg.sv
// sram22_arb_pkg: shared widths and port indices for the SRAM22 dual-port arbiter
package sram22_arb_pkg;
   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_ADDR_WIDTH  = 10;
   localparam int DEF_WMASK_WIDTH = DEF_DATA_WIDTH / 8;
   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;
endpackage

// File: rtl/sram22_rsp_slot.sv
// sram22_rsp_slot: one-entry read-response buffer with in-flight tracking
module sram22_rsp_slot
   import sram22_arb_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issue,
   input  logic [DATA_WIDTH-1:0] sram_dout,
   input  logic                  rsp_ready,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  can_issue
);
   logic pend;
   // a new read may go out only if its data will find the slot free
   assign can_issue = !pend && (!rsp_valid || rsp_ready);
   always_ff @(posedge clk) begin
      if (rst) begin
         pend      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         pend <= issue;
         if (pend) begin
            rsp_valid <= 1'b1;
            rsp_data  <= sram_dout;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/sram22_dual_port_arbiter.sv
// sram22_dual_port_arbiter: round-robin two-requester front end for a single-port SRAM22 macro
module sram22_dual_port_arbiter
   import sram22_arb_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int WMASK_WIDTH = DEF_WMASK_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   a_req_valid,
   output logic                   a_req_ready,
   input  logic                   a_req_we,
   input  logic [WMASK_WIDTH-1:0] a_req_wmask,
   input  logic [ADDR_WIDTH-1:0]  a_req_addr,
   input  logic [DATA_WIDTH-1:0]  a_req_din,
   output logic                   a_rsp_valid,
   input  logic                   a_rsp_ready,
   output logic [DATA_WIDTH-1:0]  a_rsp_data,
   input  logic                   b_req_valid,
   output logic                   b_req_ready,
   input  logic                   b_req_we,
   input  logic [WMASK_WIDTH-1:0] b_req_wmask,
   input  logic [ADDR_WIDTH-1:0]  b_req_addr,
   input  logic [DATA_WIDTH-1:0]  b_req_din,
   output logic                   b_rsp_valid,
   input  logic                   b_rsp_ready,
   output logic [DATA_WIDTH-1:0]  b_rsp_data,
   output logic                   sram_we,
   output logic [WMASK_WIDTH-1:0] sram_wmask,
   output logic [ADDR_WIDTH-1:0]  sram_addr,
   output logic [DATA_WIDTH-1:0]  sram_din,
   input  logic [DATA_WIDTH-1:0]  sram_dout
);
   logic prio;
   logic a_can_issue, b_can_issue;
   logic elig_a, elig_b, grant_a, grant_b;
   assign elig_a      = a_req_valid && (a_req_we || a_can_issue);
   assign elig_b      = b_req_valid && (b_req_we || b_can_issue);
   assign grant_a     = elig_a && (!elig_b || prio == PORT_A);
   assign grant_b     = elig_b && (!elig_a || prio == PORT_B);
   assign a_req_ready = grant_a;
   assign b_req_ready = grant_b;
   // idle cycles present a harmless read of word 0
   assign sram_we    = grant_a ? a_req_we : grant_b && b_req_we;
   assign sram_wmask = (grant_a && a_req_we) ? a_req_wmask : (grant_b && b_req_we) ? b_req_wmask : '0;
   assign sram_addr  = grant_a ? a_req_addr : grant_b ? b_req_addr : '0;
   assign sram_din   = grant_a ? a_req_din : grant_b ? b_req_din : '0;
   always_ff @(posedge clk) begin
      if (rst) prio <= PORT_A;
      else if (grant_a) prio <= PORT_B;
      else if (grant_b) prio <= PORT_A;
   end
   sram22_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_a (
      .clk       (clk),
      .rst       (rst),
      .issue     (grant_a && !a_req_we),
      .sram_dout (sram_dout),
      .rsp_ready (a_rsp_ready),
      .rsp_valid (a_rsp_valid),
      .rsp_data  (a_rsp_data),
      .can_issue (a_can_issue)
   );
   sram22_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_b (
      .clk       (clk),
      .rst       (rst),
      .issue     (grant_b && !b_req_we),
      .sram_dout (sram_dout),
      .rsp_ready (b_rsp_ready),
      .rsp_valid (b_rsp_valid),
      .rsp_data  (b_rsp_data),
      .can_issue (b_can_issue)
   );
endmodule

// File: tb/tb_sram22_dual_port_arbiter.sv
// tb_sram22_dual_port_arbiter: scoreboard bench with a macro model and a reference memory
module tb_sram22_dual_port_arbiter;
   logic clk = 1'b0;
   logic rst;
   logic a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready;
   logic b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready;
   logic [3:0] a_req_wmask, b_req_wmask, sram_wmask;
   logic [9:0] a_req_addr, b_req_addr, sram_addr;
   logic [31:0] a_req_din, b_req_din, a_rsp_data, b_rsp_data, sram_din, sram_dout;
   logic sram_we;
   logic [31:0] mem [1024];
   logic [31:0] ref_mem [1024];
   logic [31:0] qa [$];
   logic [31:0] qb [$];
   int nv = 0;
   int nf = 0;

   always #5 clk = ~clk;

   sram22_dual_port_arbiter dut (
      .clk(clk), .rst(rst),
      .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
      .a_req_wmask(a_req_wmask), .a_req_addr(a_req_addr), .a_req_din(a_req_din),
      .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_data(a_rsp_data),
      .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
      .b_req_wmask(b_req_wmask), .b_req_addr(b_req_addr), .b_req_din(b_req_din),
      .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_data(b_rsp_data),
      .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
      .sram_din(sram_din), .sram_dout(sram_dout)
   );

   // macro: byte-masked write, registered read
   always @(posedge clk) begin
      if (sram_we) begin
         for (int i = 0; i < 4; i++) if (sram_wmask[i]) mem[sram_addr][8*i +: 8] <= sram_din[8*i +: 8];
      end else begin
         sram_dout <= mem[sram_addr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nv++;
      if (act !== exp) begin
         nf++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic take_req(input bit p, input logic we, input logic [3:0] m, input logic [9:0] ad, input logic [31:0] d);
      if (we) begin
         for (int i = 0; i < 4; i++) if (m[i]) ref_mem[ad][8*i +: 8] = d[8*i +: 8];
      end else if (p) begin
         qb.push_back(ref_mem[ad]);
      end else begin
         qa.push_back(ref_mem[ad]);
      end
   endtask

   // monitor: accepted requests feed the reference memory, responses are popped and compared
   always @(negedge clk) begin
      if (rst) begin
         qa.delete();
         qb.delete();
      end else begin
         if (a_rsp_valid && a_rsp_ready) begin
            if (qa.size() == 0) check("a_rsp_unexpected", 32'd1, 32'd0);
            else check("a_rsp_data", a_rsp_data, qa.pop_front());
         end
         if (b_rsp_valid && b_rsp_ready) begin
            if (qb.size() == 0) check("b_rsp_unexpected", 32'd1, 32'd0);
            else check("b_rsp_data", b_rsp_data, qb.pop_front());
         end
         if (a_req_ready && b_req_ready) check("single_grant", 32'd2, 32'd1);
         if ((a_req_ready && !a_req_valid) || (b_req_ready && !b_req_valid)) check("ready_without_valid", 32'd1, 32'd0);
         if (a_req_valid && a_req_we && !b_req_valid) check("a_lone_write_ready", {31'd0, a_req_ready}, 32'd1);
         if (b_req_valid && b_req_we && !a_req_valid) check("b_lone_write_ready", {31'd0, b_req_ready}, 32'd1);
         if (a_req_valid && a_req_ready) take_req(1'b0, a_req_we, a_req_wmask, a_req_addr, a_req_din);
         if (b_req_valid && b_req_ready) take_req(1'b1, b_req_we, b_req_wmask, b_req_addr, b_req_din);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic req(input bit p, input logic we, input logic [3:0] m, input logic [9:0] ad, input logic [31:0] d);
      bit ok = 1'b0;
      if (p) {b_req_valid, b_req_we, b_req_wmask, b_req_addr, b_req_din} = {1'b1, we, m, ad, d};
      else   {a_req_valid, a_req_we, a_req_wmask, a_req_addr, a_req_din} = {1'b1, we, m, ad, d};
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = p ? b_req_ready : a_req_ready;
      end
      if (!ok) check("req_accept_timeout", 32'd0, 32'd1);
      tick();
      if (p) b_req_valid = 1'b0;
      else   a_req_valid = 1'b0;
   endtask

   task automatic expect_rsp(input bit p, input string name, input logic [31:0] exp);
      bit ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = p ? b_rsp_valid : a_rsp_valid;
      end
      if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
      else check(name, p ? b_rsp_data : a_rsp_data, exp);
      tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i] = 32'd0;
         ref_mem[i] = 32'd0;
      end
      sram_dout = 32'd0;
      rst = 1'b1;
      {a_req_valid, a_req_we, a_req_wmask, a_req_addr, a_req_din} = '0;
      {b_req_valid, b_req_we, b_req_wmask, b_req_addr, b_req_din} = '0;
      a_rsp_ready = 1'b1;
      b_rsp_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_a_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
      check("rst_b_rsp_valid", {31'd0, b_rsp_valid}, 32'd0);
      check("rst_a_rsp_data", a_rsp_data, 32'd0);
      check("rst_b_rsp_data", b_rsp_data, 32'd0);
      check("rst_sram_we", {31'd0, sram_we}, 32'd0);
      tick();
      // basic write/read and read latency
      req(1'b0, 1'b1, 4'hF, 10'd5, 32'hDEADBEEF);
      req(1'b0, 1'b0, 4'h0, 10'd5, 32'd0);
      @(negedge clk);
      check("lat_pend_cycle", {31'd0, a_rsp_valid}, 32'd0);
      @(negedge clk);
      check("lat_rsp_valid", {31'd0, a_rsp_valid}, 32'd1);
      check("lat_rsp_data", a_rsp_data, 32'hDEADBEEF);
      tick();
      // byte mask merge
      req(1'b0, 1'b1, 4'hF, 10'h3FF, 32'h11223344);
      req(1'b1, 1'b1, 4'b0101, 10'h3FF, 32'hAABBCCDD);
      req(1'b0, 1'b0, 4'h0, 10'h3FF, 32'd0);
      expect_rsp(1'b0, "byte_mask", 32'h11BB33DD);
      req(1'b1, 1'b1, 4'hF, 10'd1, 32'd1);
      // contention right after reset: a first, then strict alternation
      rst = 1'b1;
      tick();
      rst = 1'b0;
      {a_req_valid, a_req_we, a_req_addr} = {1'b1, 1'b0, 10'd5};
      {b_req_valid, b_req_we, b_req_addr} = {1'b1, 1'b0, 10'h3FF};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("contend_grant_%0d", i), {30'd0, a_req_ready, b_req_ready}, (i % 2) ? 32'd1 : 32'd2);
         tick();
      end
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      repeat (4) tick();
      // backpressure on a while b keeps writing
      a_rsp_ready = 1'b0;
      req(1'b0, 1'b0, 4'h0, 10'd1, 32'd0);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = a_rsp_valid;
         end
         check("bp_rsp_arrives", {31'd0, seen}, 32'd1);
      end
      tick();
      {a_req_valid, a_req_we, a_req_addr} = {1'b1, 1'b0, 10'd2};
      {b_req_valid, b_req_we, b_req_wmask} = {1'b1, 1'b1, 4'hF};
      for (int i = 0; i < 5; i++) begin
         b_req_addr = 10'(16 + i);
         b_req_din = $urandom;
         @(negedge clk);
         check("bp_a_rsp_valid", {31'd0, a_rsp_valid}, 32'd1);
         check("bp_a_rsp_data", a_rsp_data, 32'd1);
         check("bp_a_req_ready", {31'd0, a_req_ready}, 32'd0);
         check("bp_b_req_ready", {31'd0, b_req_ready}, 32'd1);
         tick();
      end
      a_rsp_ready = 1'b1;
      b_req_valid = 1'b0;
      @(negedge clk);
      check("bp_release_ready", {31'd0, a_req_ready}, 32'd1);
      tick();
      a_req_valid = 1'b0;
      repeat (3) tick();
      // write on b then read on a of the same word in the next cycle
      {b_req_valid, b_req_we, b_req_wmask, b_req_addr, b_req_din} = {1'b1, 1'b1, 4'hF, 10'd9, 32'hCAFEF00D};
      @(negedge clk);
      check("hazard_write_ready", {31'd0, b_req_ready}, 32'd1);
      tick();
      b_req_valid = 1'b0;
      {a_req_valid, a_req_we, a_req_addr} = {1'b1, 1'b0, 10'd9};
      @(negedge clk);
      check("hazard_read_ready", {31'd0, a_req_ready}, 32'd1);
      tick();
      a_req_valid = 1'b0;
      expect_rsp(1'b0, "hazard_data", 32'hCAFEF00D);
      repeat (2) tick();
      // reset in the cycle after a read grant drops the read
      req(1'b0, 1'b0, 4'h0, 10'd9, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("midrst_no_rsp", {31'd0, a_rsp_valid}, 32'd0);
      end
      tick();
      a_rsp_ready = 1'b0;
      {a_req_valid, a_req_we, a_req_addr} = {1'b1, 1'b0, 10'd5};
      {b_req_valid, b_req_we, b_req_addr} = {1'b1, 1'b0, 10'h3FF};
      @(negedge clk);
      check("midrst_prio_a", {30'd0, a_req_ready, b_req_ready}, 32'd2);
      tick();
      a_req_valid = 1'b0;
      @(negedge clk);
      check("midrst_b_next", {31'd0, b_req_ready}, 32'd1);
      tick();
      b_req_valid = 1'b0;
      expect_rsp(1'b0, "midrst_read", 32'hDEADBEEF);
      a_rsp_ready = 1'b1;
      repeat (4) tick();
      // randomized traffic against the reference memory
      for (int i = 0; i < 600; i++) begin
         {a_req_valid, a_req_we, a_req_wmask, a_req_din} = {1'($urandom), 1'($urandom), 4'($urandom), 32'($urandom)};
         {b_req_valid, b_req_we, b_req_wmask, b_req_din} = {1'($urandom), 1'($urandom), 4'($urandom), 32'($urandom)};
         a_req_addr = 10'($urandom_range(0, 15));
         b_req_addr = 10'($urandom_range(0, 15));
         a_rsp_ready = ($urandom % 4) != 0;
         b_rsp_ready = ($urandom % 4) != 0;
         tick();
      end
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      a_rsp_ready = 1'b1;
      b_rsp_ready = 1'b1;
      repeat (10) tick();
      check("drain_a", qa.size(), 32'd0);
      check("drain_b", qb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
      $finish;
   end
endmodule
